// File: rtl/nios_sampler_cpu_cpu_debug_host_jtag.sv
// Virtual-JTAG initiator for the CPU debug slave. Each accepted command performs one
// IR load followed by a single SR_WIDTH-bit DR scan, then presents the captured bits.
module nios_sampler_cpu_cpu_debug_host_jtag #(
  parameter int unsigned SR_WIDTH   = 38,
  parameter int unsigned IR_WIDTH   = 2,
  parameter int unsigned TCK_HALF   = 2,
  parameter int unsigned RTI_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned HcW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int unsigned RcW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRti,
    StDone
  } state_e;

  state_e              state;
  logic [HcW-1:0]      half_cnt;
  logic [5:0]          bit_cnt;
  logic [RcW-1:0]      rti_cnt;
  logic [SR_WIDTH-1:0] sr;

  logic running;
  logic tick;
  logic tck_rise;
  logic tck_fall;

  // tck edge strobes: an edge happens on the clk where the half-period counter wraps
  always_comb begin
    running  = (state != StIdle) && (state != StDone);
    tick     = running && (half_cnt == HcW'(TCK_HALF - 1));
    tck_rise = tick && !vji_tck;
    tck_fall = tick && vji_tck;
  end

  // Scan sequencer: tck generation, state walk, shifting and response handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
      sr         <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      busy       <= 1'b0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
    end else begin
      if (running) begin
        if (tick) begin
          half_cnt <= '0;
          vji_tck  <= ~vji_tck;
        end else begin
          half_cnt <= half_cnt + HcW'(1);
        end
      end

      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            state     <= StUir;
            vji_ir_in <= cmd_ir;
            sr        <= cmd_data;
            half_cnt  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            vji_uir   <= 1'b1;
          end
        end

        StUir: begin
          if (tck_fall) begin
            state   <= StCdr;
            vji_uir <= 1'b0;
            vji_cdr <= 1'b1;
          end
        end

        StCdr: begin
          if (tck_rise) begin
            rsp_ir_out <= vji_ir_out;
          end
          if (tck_fall) begin
            state   <= StSdr;
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= sr[0];
            bit_cnt <= '0;
          end
        end

        StSdr: begin
          if (tck_rise) begin
            sr      <= {vji_tdo, sr[SR_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (tck_fall) begin
            if (bit_cnt == 6'(SR_WIDTH)) begin
              state   <= StUdr;
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi <= sr[0];
            end
          end
        end

        StUdr: begin
          if (tck_fall) begin
            state   <= StRti;
            vji_udr <= 1'b0;
            vji_rti <= 1'b1;
            rti_cnt <= '0;
          end
        end

        StRti: begin
          if (tck_fall) begin
            if (rti_cnt == RcW'(RTI_CYCLES - 1)) begin
              state   <= StDone;
              vji_rti <= 1'b0;
            end else begin
              rti_cnt <= rti_cnt + RcW'(1);
            end
          end
        end

        StDone: begin
          // Response is raised one clk after entering DONE and held until consumed
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_sampler_cpu_cpu_debug_host_jtag.sv
// Bench for the virtual-JTAG initiator: default-parameter instance with a
// stimulus-side scan model, plus a fast instance (TCK_HALF=1, RTI_CYCLES=1).
module tb_nios_sampler_cpu_cpu_debug_host_jtag;

  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam int TH  = 2;
  localparam int RTI = 4;
  localparam int LAT = (3 + SRW + RTI) * 2 * TH + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [IRW-1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [SRW-1:0] cmd_data, rsp_data;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  int             tdo_mode;  // 0 random, 1 tied high, 2 loopback
  logic           tdo_drv;

  assign vji_tdo = (tdo_mode == 2) ? vji_tdi : tdo_drv;

  nios_sampler_cpu_cpu_debug_host_jtag dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_ir_out (rsp_ir_out),
    .busy       (busy),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  // Fast instance with looped-back tdo
  logic           cmd_valid6, cmd_ready6, rsp_valid6, rsp_ready6, busy6;
  logic [IRW-1:0] cmd_ir6, rsp_ir_out6, vji_ir_in6;
  logic [SRW-1:0] cmd_data6, rsp_data6;
  logic           vji_tck6, vji_tdi6;
  logic           vji_uir6, vji_cdr6, vji_sdr6, vji_udr6, vji_rti6;

  nios_sampler_cpu_cpu_debug_host_jtag #(
    .SR_WIDTH   (SRW),
    .IR_WIDTH   (IRW),
    .TCK_HALF   (1),
    .RTI_CYCLES (1)
  ) dut6 (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid6),
    .cmd_ready  (cmd_ready6),
    .cmd_ir     (cmd_ir6),
    .cmd_data   (cmd_data6),
    .rsp_valid  (rsp_valid6),
    .rsp_ready  (rsp_ready6),
    .rsp_data   (rsp_data6),
    .rsp_ir_out (rsp_ir_out6),
    .busy       (busy6),
    .vji_tck    (vji_tck6),
    .vji_tdi    (vji_tdi6),
    .vji_tdo    (vji_tdi6),
    .vji_ir_in  (vji_ir_in6),
    .vji_ir_out (2'b11),
    .vji_uir    (vji_uir6),
    .vji_cdr    (vji_cdr6),
    .vji_sdr    (vji_sdr6),
    .vji_udr    (vji_udr6),
    .vji_rti    (vji_rti6)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctl"},
          {60'd0, cmd_ready, rsp_valid, busy, vji_tck}, 64'h8);
    check({tag, "_vji"},
          {58'd0, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 64'h0);
    check({tag, "_data"}, {24'd0, rsp_data, rsp_ir_out, vji_ir_in}, 64'h0);
  endtask

  // One full command. abort_bit >= 0 pulses reset after that many SDR bits.
  task automatic run_scan(input logic [IRW-1:0] ir, input logic [SRW-1:0] data,
                          input int mode, input logic [IRW-1:0] irout,
                          input int hold, input int abort_bit);
    logic [SRW-1:0] exp_data;
    logic [SRW-1:0] snap;
    logic           prev_tck;
    int cyc, nbits, rises, c_uir, c_cdr, c_sdr, c_udr, c_rti;
    int onehot_bad, ir_bad, rdy_bad, tdi_bad, hold_bad, rv_bad;
    exp_data = '0;
    prev_tck = 1'b0;
    cyc = 0; nbits = 0; rises = 0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
    onehot_bad = 0; ir_bad = 0; rdy_bad = 0; tdi_bad = 0; hold_bad = 0; rv_bad = 0;
    tdo_mode   = mode;
    tdo_drv    = (mode == 1) ? 1'b1 : 1'($urandom);
    vji_ir_out = irout;

    check("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = data;
    @(negedge clk);
    // Post-accept changes must be ignored
    cmd_valid = 1'b0;
    cmd_ir    = IRW'($urandom);
    cmd_data  = {6'($urandom), 32'($urandom)};

    while (cyc < 1000) begin
      if (rsp_valid) break;
      c_uir += int'(vji_uir);
      c_cdr += int'(vji_cdr);
      c_sdr += int'(vji_sdr);
      c_udr += int'(vji_udr);
      c_rti += int'(vji_rti);
      if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti)) > 1)
        onehot_bad++;
      if (vji_ir_in !== ir) ir_bad++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
      if (vji_tck && !prev_tck) begin
        rises++;
        if (vji_sdr && nbits < SRW) begin
          exp_data[nbits] = vji_tdo;
          if (vji_tdi !== data[nbits]) tdi_bad++;
          nbits++;
          if (nbits == abort_bit) begin
            reset_n = 1'b0;
            #1;
            check_reset_values("abort");
            repeat (3) begin
              @(negedge clk);
              if (rsp_valid !== 1'b0 || busy !== 1'b0) rv_bad++;
            end
            reset_n = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) rv_bad++;
            check("abort_no_rsp", 64'(rv_bad), 64'd0);
            return;
          end
        end
      end
      prev_tck = vji_tck;
      if (vji_tck && mode == 0) tdo_drv = 1'($urandom);
      @(negedge clk);
      cyc++;
    end

    check("latency", 64'(cyc), 64'(LAT));
    check("tck_rises", 64'(rises), 64'(3 + SRW + RTI));
    check("uir_len", 64'(c_uir), 64'(2 * TH));
    check("cdr_len", 64'(c_cdr), 64'(2 * TH));
    check("sdr_len", 64'(c_sdr), 64'(SRW * 2 * TH));
    check("udr_len", 64'(c_udr), 64'(2 * TH));
    check("rti_len", 64'(c_rti), 64'(RTI * 2 * TH));
    check("one_hot", 64'(onehot_bad), 64'd0);
    check("ir_in_const", 64'(ir_bad), 64'd0);
    check("busy_no_ready", 64'(rdy_bad), 64'd0);
    check("tdi_bits", 64'(tdi_bad), 64'd0);
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_ir_out", 64'(rsp_ir_out), 64'(irout));

    snap = rsp_data;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 ||
          vji_tck !== 1'b0 || busy !== 1'b1) hold_bad++;
    end
    check("hold_stable", 64'(hold_bad), 64'd0);

    // New command offered in the same clk as the response handshake
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("no_overlap", {60'd0, busy, cmd_ready, rsp_valid, vji_uir}, 64'b0100);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("idle_after", {62'd0, busy, cmd_ready}, 64'b01);
  endtask

  initial begin
    int cyc6, toggles6;
    logic prev6;
    logic [SRW-1:0] d;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
    vji_ir_out = '0; tdo_mode = 0; tdo_drv = 1'b0;
    cmd_valid6 = 1'b0; cmd_ir6 = '0; cmd_data6 = '0; rsp_ready6 = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Loopback: data returns unchanged
    run_scan(2'b01, 38'h2A_5A5A_5A5A, 2, 2'b00, 2, -1);
    check("t1_loop_data", 64'(rsp_data), 64'h2A_5A5A_5A5A);

    // tdo tied high
    run_scan(2'b11, '0, 1, 2'b01, 1, -1);
    check("t2_ones", 64'(rsp_data), 64'h3F_FFFF_FFFF);

    // IR status capture and long hold on rsp_ready
    run_scan(2'b10, {6'($urandom), 32'($urandom)}, 0, 2'b10, 20, -1);

    // Random scans
    repeat (3) begin
      run_scan(IRW'($urandom), {6'($urandom), 32'($urandom)}, 0, IRW'($urandom),
               int'($urandom_range(0, 5)), -1);
    end

    // Reset mid-scan, then a clean command
    run_scan(2'b01, {6'($urandom), 32'($urandom)}, 0, 2'b11, 0, 17);
    d = {6'($urandom), 32'($urandom)};
    run_scan(2'b10, d, 2, 2'b01, 1, -1);
    check("after_abort_data", 64'(rsp_data), 64'(d));

    // Fast instance
    d = {6'($urandom), 32'($urandom)};
    check("t6_ready", {63'd0, cmd_ready6}, 64'd1);
    cmd_valid6 = 1'b1;
    cmd_ir6    = 2'b01;
    cmd_data6  = d;
    @(negedge clk);
    cmd_valid6 = 1'b0;
    cyc6 = 0;
    toggles6 = 0;
    prev6 = vji_tck6;
    while (!rsp_valid6 && cyc6 < 1000) begin
      @(negedge clk);
      cyc6++;
      if (vji_tck6 !== prev6) toggles6++;
      prev6 = vji_tck6;
    end
    check("t6_latency", 64'(cyc6), 64'd85);
    check("t6_toggles", 64'(toggles6), 64'd84);
    check("t6_data", 64'(rsp_data6), 64'(d));
    check("t6_ir_out", 64'(rsp_ir_out6), 64'd3);
    rsp_ready6 = 1'b1;
    @(negedge clk);
    rsp_ready6 = 1'b0;
    check("t6_idle", {62'd0, busy6, cmd_ready6}, 64'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
